// File: rtl/adc0809_seq.sv
// ADC0809 conversion sequencer: converter clock, ALE/START/OE handshake, synchronized EOC with timeout, registered result.
// Optional `ADC_AVG_EN: publish a 4-sample running average instead of the raw sample.
module adc0809_seq #(
  parameter int CLK_DIV     = 50,
  parameter int PULSE_CYC   = 4,
  parameter int OE_CYC      = 4,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] chan,
  input  logic       eoc,
  input  logic [7:0] adc_data,
  output logic [2:0] addr,
  output logic       ale,
  output logic       start,
  output logic       out_en,
  output logic       adc_clk,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       timeout,
  output logic [7:0] led
);

  localparam int M1   = (CLK_DIV > PULSE_CYC) ? CLK_DIV : PULSE_CYC;
  localparam int M2   = (OE_CYC > GAP_CYC) ? OE_CYC : GAP_CYC;
  localparam int M3   = (M1 > M2) ? M1 : M2;
  localparam int MAXP = (M3 > TIMEOUT_CYC) ? M3 : TIMEOUT_CYC;
  localparam int CW   = $clog2(MAXP + 1);

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] OE_LAST    = CW'(OE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_SAT    = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ALE, S_START, S_WAIT_LO, S_WAIT_HI, S_READ, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0] div_q;
  logic          adc_clk_q;
  logic          eoc_m_q, eoc_s_q;
  logic [2:0]    addr_q, addr_d;
  logic          ale_q, start_q, oe_q, valid_q, timeout_q;
  logic [7:0]    result_q, sample_d;
  logic          capture, tmo_set;

`ifdef ADC_AVG_EN
  logic [7:0] hist_q [3];
  logic [9:0] sum;

  always_comb begin
    sum      = {2'b00, adc_data} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
    sample_d = sum[9:2];
  end

  // History advances only on good captures; timeouts leave it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q[0] <= '0;
      hist_q[1] <= '0;
      hist_q[2] <= '0;
    end else if (capture) begin
      hist_q[0] <= adc_data;
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
    end
  end
`else
  always_comb sample_d = adc_data;
`endif

  always_comb begin
    state_d = state_q;
    cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
    cnt_d   = cnt_inc;
    addr_d  = addr_q;
    capture = 1'b0;
    tmo_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          addr_d  = chan;
          state_d = S_SETUP;
        end
      end
      S_SETUP:   if (cnt_q == PULSE_LAST) begin state_d = S_ALE;     cnt_d = '0; end
      S_ALE:     if (cnt_q == PULSE_LAST) begin state_d = S_START;   cnt_d = '0; end
      S_START:   if (cnt_q == PULSE_LAST) begin state_d = S_WAIT_LO; cnt_d = '0; end
      S_WAIT_LO: begin
        if (!eoc_s_q) begin
          state_d = S_WAIT_HI;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          tmo_set = 1'b1;
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_WAIT_HI: begin
        if (eoc_s_q) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          tmo_set = 1'b1;
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        if (cnt_q == OE_LAST) begin
          capture = 1'b1;
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP:     if (cnt_q == GAP_LAST) begin state_d = S_IDLE; cnt_d = '0; end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so they align with state_q and never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      adc_clk_q <= 1'b0;
      eoc_m_q   <= 1'b0;
      eoc_s_q   <= 1'b0;
      addr_q    <= '0;
      ale_q     <= 1'b0;
      start_q   <= 1'b0;
      oe_q      <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (div_q == DIV_LAST) begin
        div_q     <= '0;
        adc_clk_q <= ~adc_clk_q;
      end else begin
        div_q <= div_q + CW'(1);
      end
      eoc_m_q <= eoc;
      eoc_s_q <= eoc_m_q;
      addr_q  <= addr_d;
      ale_q   <= (state_d == S_ALE) || (state_d == S_START);
      start_q <= (state_d == S_START);
      oe_q    <= (state_d == S_READ);
      valid_q <= capture;
      if (capture) begin
        result_q  <= sample_d;
        timeout_q <= 1'b0;
      end else if (tmo_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign addr         = addr_q;
  assign ale          = ale_q;
  assign start        = start_q;
  assign out_en       = oe_q;
  assign adc_clk      = adc_clk_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign timeout      = timeout_q;
  assign led          = result_q;

endmodule

// File: tb/tb_adc0809_seq.sv
// Scoreboard bench for adc0809_seq: stimulus pushes expected samples, a monitor pops them on result_valid.
module tb_adc0809_seq;
  localparam int CLK_DIV = 2, PULSE_CYC = 4, OE_CYC = 4, GAP_CYC = 16, TIMEOUT_CYC = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] chan = '0;
  logic       eoc = 1'b1;
  logic [7:0] adc_data = '0;
  logic [2:0] addr;
  logic       ale, start, out_en, adc_clk, result_valid, timeout;
  logic [7:0] result, led;

  adc0809_seq #(
    .CLK_DIV(CLK_DIV), .PULSE_CYC(PULSE_CYC), .OE_CYC(OE_CYC),
    .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .chan(chan), .eoc(eoc),
    .adc_data(adc_data), .addr(addr), .ale(ale), .start(start), .out_en(out_en),
    .adc_clk(adc_clk), .result(result), .result_valid(result_valid),
    .timeout(timeout), .led(led)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0, n_bad = 0, n_valid = 0, cyc = 0, eoc_rise_cyc = 0;
  bit         good_mode = 1'b1;
  logic [7:0] exp_q [$];
  logic [7:0] last_exp = '0;
`ifdef ADC_AVG_EN
  logic [7:0] hist [3] = '{8'd0, 8'd0, 8'd0};
`endif

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] d);
`ifdef ADC_AVG_EN
    logic [9:0] s;
    s = {2'b00, d} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = d;
    return s[9:2];
`else
    return d;
`endif
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0: return ale;
      1: return start;
      2: return out_en;
      3: return eoc;
      default: return timeout;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic lvl, input int lim, input string nm);
    int i = 0;
    while (sig(sel) !== lvl && i < lim) begin
      @(negedge clk);
      i++;
    end
    check(nm, 32'(sig(sel) === lvl), 32'd1);
  endtask

  task automatic wait_valid(input int target, input string nm);
    int i = 0;
    while (n_valid < target && i < 400) begin
      @(negedge clk);
      i++;
    end
    check(nm, 32'(n_valid >= target), 32'd1);
  endtask

  task automatic run_good(input logic [2:0] ch, input logic [7:0] d, input int target, input string nm);
    chan = ch;
    adc_data = d;
    good_mode = 1'b1;
    last_exp = model(d);
    exp_q.push_back(last_exp);
    enable = 1'b1;
    wait_for(0, 1'b1, 60, "ale_rise");
    enable = 1'b0;
    wait_valid(target, nm);
    repeat (GAP_CYC + 4) @(negedge clk);
  endtask

  // Converter model: EOC falls 10 cycles after START falls, rises 50 cycles later.
  initial begin
    logic sp = 1'b0;
    forever begin
      @(negedge clk);
      if (sp && !start && good_mode) begin
        repeat (10) @(negedge clk);
        eoc = 1'b0;
        repeat (50) @(negedge clk);
        eoc = 1'b1;
        eoc_rise_cyc = cyc;
      end
      sp = start;
    end
  end

  always @(negedge clk) begin
    if (reset && result_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e));
        check("led", 32'(led), 32'(e));
        check("valid_latency", 32'(cyc - eoc_rise_cyc), 32'(OE_CYC + 3));
        check("timeout_clr_on_valid", 32'(timeout), 32'd0);
      end
      n_valid++;
    end
  end

  initial begin
    int n;
    int t [3];
    logic prev;
    #2;
    check("reset_outputs", {addr, ale, start, out_en, adc_clk, result, result_valid, timeout, led}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    prev = adc_clk;
    n = 0;
    t = '{0, 0, 0};
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (adc_clk !== prev) begin
        t[n] = i;
        n++;
        prev = adc_clk;
      end
    end
    check("adc_clk_half1", 32'(t[1] - t[0]), 32'(CLK_DIV));
    check("adc_clk_half2", 32'(t[2] - t[1]), 32'(CLK_DIV));
    check("idle_no_ale", 32'(ale), 32'd0);

    // First conversion: pulse sequence, addr hold, OE width.
    chan = 3'd5;
    adc_data = 8'hA5;
    last_exp = model(8'hA5);
    exp_q.push_back(last_exp);
    enable = 1'b1;
    wait_for(0, 1'b1, 60, "ale_rise_c1");
    enable = 1'b0;
    check("addr_at_ale", 32'(addr), 32'd5);
    chan = 3'd2;
    n = 0;
    while (ale && !start && n < 20) begin n++; @(negedge clk); end
    check("ale_only_cycles", 32'(n), 32'(PULSE_CYC));
    n = 0;
    while (ale && start && n < 20) begin n++; @(negedge clk); end
    check("ale_start_cycles", 32'(n), 32'(PULSE_CYC));
    check("ale_start_drop", {ale, start}, 32'd0);
    wait_for(2, 1'b1, 200, "oe_rise");
    n = 0;
    while (out_en && n < 20) begin n++; @(negedge clk); end
    check("oe_cycles", 32'(n), 32'(OE_CYC));
    check("addr_held", 32'(addr), 32'd5);
    wait_valid(1, "valid_c1");
    repeat (GAP_CYC + 4) @(negedge clk);

    // Second conversion picks up the new channel; enable drops during WAIT_HI.
    adc_data = 8'h3C;
    last_exp = model(8'h3C);
    exp_q.push_back(last_exp);
    enable = 1'b1;
    wait_for(0, 1'b1, 60, "ale_rise_c2");
    check("addr_next_conv", 32'(addr), 32'd2);
    wait_for(3, 1'b0, 100, "eoc_low");
    repeat (5) @(negedge clk);
    enable = 1'b0;
    wait_valid(2, "valid_c2");
    n = 0;
    repeat (60) begin @(negedge clk); if (ale) n++; end
    check("stopped_in_idle", 32'(n), 32'd0);

    // Stuck-high EOC: timeout after TIMEOUT_CYC in WAIT_LO, result preserved.
    good_mode = 1'b0;
    adc_data = 8'hFF;
    enable = 1'b1;
    wait_for(0, 1'b1, 60, "ale_rise_tmo");
    enable = 1'b0;
    wait_for(1, 1'b1, 20, "start_rise_tmo");
    wait_for(1, 1'b0, 20, "start_fall_tmo");
    n = 0;
    while (!timeout && n < 300) begin @(negedge clk); n++; end
    check("timeout_latency", 32'(n), 32'(TIMEOUT_CYC));
    check("result_kept", 32'(result), 32'(last_exp));
    check("led_kept", 32'(led), 32'(last_exp));
    repeat (GAP_CYC + 4) @(negedge clk);
    check("timeout_sticky", 32'(timeout), 32'd1);

    run_good(3'd1, 8'h5A, 3, "valid_after_tmo");
    check("timeout_cleared", 32'(timeout), 32'd0);

    // Reset in READ: outputs drop at once and the sample is not taken.
    adc_data = 8'h77;
    good_mode = 1'b1;
    enable = 1'b1;
    wait_for(0, 1'b1, 60, "ale_rise_rst");
    enable = 1'b0;
    wait_for(2, 1'b1, 200, "oe_rise_rst");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_in_read", {addr, ale, start, out_en, adc_clk, result, result_valid, timeout, led}, 32'd0);
`ifdef ADC_AVG_EN
    hist = '{8'd0, 8'd0, 8'd0};
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;

    run_good(3'd0, 8'd40, 4, "valid_s40");
    run_good(3'd0, 8'd80, 5, "valid_s80");
    run_good(3'd0, 8'd120, 6, "valid_s120");
    run_good(3'd0, 8'd160, 7, "valid_s160");
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adc0809_seq.md
Name: adc0809_seq

Overview:
Upstream conversion sequencer for the ADC0809-class 8-bit converter that feeds the motor PWM and FND stages. Generates the converter clock and the ALE/START/OE handshake, and tracks EOC. Publishes each 8-bit sample on a registered result bus with a one-cycle valid strobe. Includes an EOC timeout so a missing or stuck converter cannot hang the design.

Parameters:
CLK_DIV, 50, adc_clk half-period in clk cycles (adc_clk = clk / (2*CLK_DIV)); legal range 1..1023
PULSE_CYC, 4, width of ALE and START high pulses, and ADDR-to-ALE setup, in clk cycles; legal range 1..255
OE_CYC, 4, clk cycles OE is held high before the data bus is sampled; legal range 2..255
GAP_CYC, 16, idle clk cycles between conversions; legal range 1..65535
TIMEOUT_CYC, 200000, maximum clk cycles spent in either EOC wait state before abort

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
enable  input  1  1 = free-running conversions; 0 = stop after the current conversion
chan  input  3  analog channel; sampled when leaving IDLE
eoc  input  1  converter end-of-conversion, asynchronous to clk
adc_data  input  8  converter tri-state data bus
addr  output  3  channel address to converter
ale  output  1  address latch enable
start  output  1  conversion start
out_en  output  1  converter output enable (OE)
adc_clk  output  1  converter clock
result  output  8  last good sample, registered
result_valid  output  1  one-clk pulse when result updates
timeout  output  1  sticky; set on EOC timeout, cleared by reset or next good sample
led  output  8  mirror of result

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM in IDLE; divider, counters and EOC synchronizer cleared.
- adc_clk: free-running toggle every CLK_DIV clk cycles whenever reset is high, independent of FSM state.
- eoc passes through a 2-flop synchronizer. FSM uses only the synchronized value (eoc_s); all EOC latencies below include these 2 cycles.
- FSM states and transitions:
  - IDLE: if enable=1, latch chan into addr, clear counter, go to SETUP.
  - SETUP (PULSE_CYC cycles, addr stable): go to ALE_HI.
  - ALE_HI (PULSE_CYC cycles): ale=1; go to START_HI.
  - START_HI (PULSE_CYC cycles): ale=1, start=1; on exit ale and start drop together; go to WAIT_LO.
  - WAIT_LO: wait for eoc_s=0, then go to WAIT_HI.
  - WAIT_HI: wait for eoc_s=1, then go to READ.
  - READ (OE_CYC cycles): out_en=1. On the last cycle, capture adc_data into result, pulse result_valid the following cycle, clear timeout. Go to GAP.
  - GAP (GAP_CYC cycles): then go to IDLE.
- Timeout: in WAIT_LO or WAIT_HI, reaching TIMEOUT_CYC cycles sets timeout=1, leaves result unchanged, gives no result_valid, and goes to GAP.
- enable=0 mid-conversion: current conversion completes; the FSM stops in IDLE.
- chan change mid-conversion: ignored until the next IDLE exit.
- Counters saturate. Width is ceil(log2) of the largest parameter.
- Output latency: result_valid asserts OE_CYC+1 clk cycles after eoc_s rises.
- led equals result combinationally from the register.

Optional Feature:
ADC_AVG_EN:
- Defined: result is the 4-sample running average of captured samples, computed as a 10-bit sum >> 2 with truncation. After reset, the first three results average against zero-filled history. result_valid timing is unchanged. A timeout does not push any sample into the history.
- Undefined: result is the raw captured sample.

Test Plan:
1. CLK_DIV=2, enable=1, reset released -> adc_clk toggles every 2 clk cycles; sequence is ale high 4 cycles, then ale+start high 4 cycles, then both low.
2. Converter model: eoc low 10 cycles after start falls, high 50 cycles later, adc_data=8'hA5 -> out_en high 4 cycles; result=8'hA5 and led=8'hA5; result_valid high exactly 1 cycle, 5 cycles after eoc_s rises.
3. eoc held high forever, TIMEOUT_CYC=100 -> timeout=1 after 100 cycles in WAIT_LO; result keeps its prior value; no result_valid. A following good conversion clears timeout.
4. chan=3'd5 at IDLE exit, then chan=3'd2 mid-conversion -> addr stays 5 for the whole conversion and reads 2 on the next conversion.
5. enable dropped during WAIT_HI -> conversion completes with one result_valid, then the FSM holds IDLE with no further ale.
6. Reset asserted during READ -> all outputs 0 immediately. With ADC_AVG_EN and samples 40,80,120,160 -> results 10,30,60,100.
